oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Bus scheduler between the 6502 core and the NES sprite (OAM) DMA engine; sits between the cpu block and the system memory bus.
- In IDLE it passes CPU bus cycles straight through. A CPU write to the DMA trigger register ($4014) stalls the CPU via cpu_rdy, then copies 256 bytes from page {value,8'h00..8'hFF} to the OAM data port ($2004).
- When the copy finishes, bus ownership returns to the CPU.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address whose write starts a DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clk  in  1  system clock, one CPU cycle per edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address.
- cpu_d_out  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_rdy  out  1  1 = CPU may advance; 0 = CPU must hold its state.
- mem_addr  out  16  address to the system bus.
- mem_d_out  out  8  write data to the system bus.
- mem_we  out  1  write strobe to the system bus.
- mem_d_in  in  8  read data from the system bus, combinational in the same cycle.
- dma_busy  out  1  high in every non-IDLE state.
- dma_done  out  1  one-cycle pulse in the cycle after the final OAM write.

Behaviour:
- Clocking and reset: already decided — one clock, clk; reset rst is synchronous and active-high.
- On reset, all of the following take effect at the next clk edge with rst=1:
  - state=IDLE, parity=0, cnt=8'h00, page=8'h00, latch=8'h00.
  - cpu_rdy=1, dma_busy=0, dma_done=0.
  - A reset mid-DMA aborts the transfer immediately. The CPU bus is released in the same cycle the reset state takes effect.
- Parity register: toggles every clk cycle while not in reset. parity=0 marks a "get" cycle, parity=1 a "put" cycle.
- States:
  - IDLE: mem_addr=cpu_addr, mem_d_out=cpu_d_out, mem_we=cpu_we, cpu_rdy=1. If cpu_we && cpu_addr==DMA_REG_ADDR, the CPU write still reaches the bus unchanged; latch page<=cpu_d_out, cnt<=0, and go to HALT.
  - HALT: cpu_rdy=0, mem_addr=cpu_addr, mem_we=0 (dummy read). Next state is ALIGN if parity==0, else READ. This makes READ always fall on parity==0.
  - ALIGN: cpu_rdy=0, mem_addr=cpu_addr, mem_we=0. Next state is READ.
  - READ: cpu_rdy=0, mem_addr={page,cnt}, mem_we=0. latch<=mem_d_in at the closing edge. Next state is WRITE.
  - WRITE: cpu_rdy=0, mem_addr=OAM_DATA_ADDR, mem_d_out=latch, mem_we=1.
    - If cnt==8'hFF: cnt wraps to 8'h00, go to IDLE, dma_done=1 in the next cycle.
    - Otherwise cnt<=cnt+1 and go to READ.
- Stall length: from the trigger cycle (exclusive) to the first IDLE cycle, exactly 513 cycles (HALT was on parity 1) or 514 cycles (HALT was on parity 0).
- cpu_rdy is combinational from state. It drops in the HALT cycle, i.e. the cycle immediately after the trigger write.
- Outside IDLE, CPU writes are blocked from the bus, including writes to DMA_REG_ADDR (no retrigger, page unchanged).
- Page 8'hFF is legal. Addresses $FF00–$FFFF are read, and cnt wrap never carries into page.
- A trigger in the same cycle that dma_done is high is accepted normally, because state is IDLE.
- mem_d_in is ignored in every state except READ.

Test Plan:
- Pass-through: in IDLE, CPU writes $55 to $0300 -> mem_addr=$0300, mem_d_out=$55, mem_we=1, cpu_rdy=1, dma_busy=0.
- Even-aligned DMA: memory preloaded with $0200+i = i^$A5. Write $02 to $4014 on a parity-1 cycle (HALT then lands on parity 0) -> 514-cycle stall. 256 writes to $2004 with data i^$A5 in order i=0..255, dma_done pulses once, cpu_rdy returns to 1.
- Odd-aligned DMA: same stimulus but HALT lands on parity 1 -> no ALIGN, exactly 513-cycle stall, identical data sequence.
- Retrigger ignored: during a DMA, drive cpu_we=1, cpu_addr=$4014, cpu_d_out=$07 -> no bus write, page stays $02, transfer unchanged.
- Reset mid-operation: assert rst for 1 cycle after the 100th OAM write -> next cycle state=IDLE, cpu_rdy=1, mem_we follows cpu_we, dma_done never pulses.
- Wrap edge: trigger with page $FF -> reads cover $FF00..$FFFF, the last read is $FFFF (no $0000 access), and cnt ends at $00.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//   Bus scheduler between the 6502 core and the sprite (OAM) DMA engine.
//   In IDLE, CPU bus cycles pass straight through to the system bus. A CPU
//   write to DMA_REG_ADDR stalls the CPU and copies the 256-byte page
//   {value,8'h00..8'hFF} into OAM_DATA_ADDR, one read/write pair per byte,
//   then hands the bus back to the CPU.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | CPU owns the bus, pass-through; watches for a trigger write
//   HALT  | first stall cycle, dummy read at cpu_addr
//   ALIGN | extra dummy read so that READ lands on a get (parity 0) cycle
//   READ  | read {page,cnt} from the bus into latch
//   WRITE | write latch to OAM_DATA_ADDR, advance or finish
//
// Ports
//   clk        in   system clock, one CPU cycle per edge
//   rst        in   synchronous active-high reset
//   cpu_addr   in   [15:0] CPU address
//   cpu_d_out  in   [7:0]  CPU write data
//   cpu_we     in   CPU write strobe
//   cpu_rdy    out  1 = CPU may advance, 0 = CPU holds
//   mem_addr   out  [15:0] system bus address
//   mem_d_out  out  [7:0]  system bus write data
//   mem_we     out  system bus write strobe
//   mem_d_in   in   [7:0]  system bus read data (same-cycle)
//   dma_busy   out  high in every non-IDLE state
//   dma_done   out  one-cycle pulse after the final OAM write
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_d_out,
  output logic        mem_we,
  input  logic [7:0]  mem_d_in,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        parity;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  page, page_nxt;
  logic [7:0]  latch, latch_nxt;
  logic        done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      parity   <= 1'b0;
      cnt      <= 8'h00;
      page     <= 8'h00;
      latch    <= 8'h00;
      dma_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      parity   <= ~parity;
      cnt      <= cnt_nxt;
      page     <= page_nxt;
      latch    <= latch_nxt;
      dma_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    page_nxt  = page;
    latch_nxt = latch;
    done_nxt  = 1'b0;
    cpu_rdy   = 1'b0;
    dma_busy  = 1'b1;
    mem_addr  = cpu_addr;
    mem_d_out = cpu_d_out;
    mem_we    = 1'b0;

    case (state)
      IDLE: begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
        mem_we   = cpu_we;
        // The trigger write itself still reaches the bus unchanged.
        if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
          page_nxt  = cpu_d_out;
          cnt_nxt   = 8'h00;
          state_nxt = HALT;
        end
      end
      HALT: begin
        // parity here is the current cycle; READ must fall on parity 0.
        state_nxt = parity ? READ : ALIGN;
      end
      ALIGN: begin
        state_nxt = READ;
      end
      READ: begin
        mem_addr  = {page, cnt};
        latch_nxt = mem_d_in;
        state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr  = OAM_DATA_ADDR;
        mem_d_out = latch;
        mem_we    = 1'b1;
        // 8-bit increment wraps FF->00 without touching page.
        cnt_nxt   = cnt + 8'd1;
        if (cnt == 8'hFF) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = READ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA = 16'h2004;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_d_out;
  logic        mem_we;
  logic [7:0]  mem_d_in;
  logic        dma_busy;
  logic        dma_done;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  oam_dma_ctrl #(.DMA_REG_ADDR(DMA_REG), .OAM_DATA_ADDR(OAM_DATA)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_d_out (cpu_d_out),
    .cpu_we    (cpu_we),
    .cpu_rdy   (cpu_rdy),
    .mem_addr  (mem_addr),
    .mem_d_out (mem_d_out),
    .mem_we    (mem_we),
    .mem_d_in  (mem_d_in),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done)
  );

  always #5 clk = ~clk;

  // Read-only system memory model with same-cycle read data.
  assign mem_d_in = mem[mem_addr];

  // Cycle index since reset; its LSB is the get/put parity of the cycle.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // {cpu_rdy, dma_busy, dma_done, mem_we, mem_addr, write data (only when writing)}
  function automatic logic [63:0] pack(input logic rdy, input logic busy, input logic done,
                                       input logic we, input logic [15:0] a, input logic [7:0] d);
    return {36'h0, rdy, busy, done, we, a, (we ? d : 8'h00)};
  endfunction

  function automatic logic [63:0] observed();
    return pack(cpu_rdy, dma_busy, dma_done, mem_we, mem_addr, mem_d_out);
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == DMA_REG) a = 16'h4015;
    return a;
  endfunction

  task automatic idle_cycle(input string tag, input logic we, input logic [15:0] a, input logic [7:0] d);
    next_cyc();
    cpu_we = we; cpu_addr = a; cpu_d_out = d;
    sample();
    check(tag, observed(), pack(1'b1, 1'b0, 1'b0, we, a, d));
  endtask

  // Wait (at most two cycles) for a cycle of the wanted parity and write the
  // trigger register there. Returns the parity the trigger actually used.
  task automatic trigger(input logic [7:0] page, input bit want_par, output bit used_par);
    bit fired;
    fired = 0;
    used_par = want_par;
    for (int n = 0; n < 3 && !fired; n++) begin
      next_cyc();
      if (cyc[0] == want_par || n == 2) begin
        used_par = cyc[0];
        cpu_we = 1'b1; cpu_addr = DMA_REG; cpu_d_out = page;
        sample();
        check("trigger", observed(), pack(1'b1, 1'b0, 1'b0, 1'b1, DMA_REG, page));
        fired = 1;
      end else begin
        cpu_we = 1'b0; cpu_addr = rand_addr(); cpu_d_out = 8'($urandom);
        sample();
        check("pre_trigger", observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, cpu_addr, 8'h00));
      end
    end
  endtask

  // Expected stall trace: one dummy cycle (two if the trigger was on an odd
  // cycle), then 256 read/write pairs, then a done cycle back in IDLE.
  task automatic dma_body(input logic [7:0] page, input bit trig_par, input bit retrig,
                          input int abort_at, input bit chain, input logic [7:0] next_page,
                          input logic [15:0] hold_addr);
    int ndum, len, j, i;
    logic [15:0] rd_addr;
    logic [63:0] exp;
    ndum = trig_par ? 2 : 1;
    len  = ndum + 512;
    for (int k = 0; k < len; k++) begin
      next_cyc();
      if (retrig) begin
        cpu_we = 1'b1; cpu_addr = DMA_REG; cpu_d_out = 8'h07;
      end else begin
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = hold_addr; cpu_d_out = 8'($urandom);
      end
      j = k - ndum;
      i = j / 2;
      if (k < ndum) begin
        exp = pack(1'b0, 1'b1, 1'b0, 1'b0, cpu_addr, 8'h00);
      end else if (j % 2 == 0) begin
        rd_addr = {page, 8'(i)};
        exp = pack(1'b0, 1'b1, 1'b0, 1'b0, rd_addr, 8'h00);
      end else begin
        rd_addr = {page, 8'(i)};
        exp = pack(1'b0, 1'b1, 1'b0, 1'b1, OAM_DATA, mem[rd_addr]);
      end
      if (k >= ndum && j % 2 == 0 && i == abort_at) rst = 1'b1;
      sample();
      check(retrig ? "dma_retrig" : "dma", observed(), exp);
      if (rst) begin
        next_cyc();
        rst = 1'b0;
        cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_d_out = 8'h5A;
        sample();
        check("post_reset", observed(), pack(1'b1, 1'b0, 1'b0, 1'b1, 16'h0300, 8'h5A));
        return;
      end
    end
    next_cyc();
    if (chain) begin
      cpu_we = 1'b1; cpu_addr = DMA_REG; cpu_d_out = next_page;
      sample();
      check("done_chain", observed(), pack(1'b1, 1'b0, 1'b1, 1'b1, DMA_REG, next_page));
    end else begin
      cpu_we = 1'b0; cpu_addr = hold_addr; cpu_d_out = 8'($urandom);
      sample();
      check("done", observed(), pack(1'b1, 1'b0, 1'b1, 1'b0, hold_addr, 8'h00));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit          par;
    bit          chain_par;
    logic [7:0]  pg;
    logic [7:0]  pg2;
    logic [15:0] a;

    for (int n = 0; n < 65536; n++) mem[n] = 8'($urandom);
    for (int n = 0; n < 256; n++) mem[16'h0200 + n] = 8'(n) ^ 8'hA5;

    rst = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_d_out = 8'h00;
    repeat (2) @(posedge clk);
    sample();
    check("reset_state", observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00));

    next_cyc();
    rst = 1'b0;
    cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_d_out = 8'h55;
    sample();
    check("pass_0300", observed(), pack(1'b1, 1'b0, 1'b0, 1'b1, 16'h0300, 8'h55));

    for (int n = 0; n < 20; n++) begin
      a = rand_addr();
      idle_cycle("pass_rand", 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    // Even-aligned: trigger on an odd cycle, HALT on even, ALIGN inserted.
    trigger(8'h02, 1'b1, par);
    dma_body(8'h02, par, 1'b0, -1, 1'b0, 8'h00, 16'h8000);

    // Odd-aligned: trigger on an even cycle, no ALIGN.
    trigger(8'h02, 1'b0, par);
    dma_body(8'h02, par, 1'b0, -1, 1'b0, 8'h00, 16'h8123);

    // CPU keeps hammering the trigger register during the copy.
    trigger(8'h02, 1'($urandom_range(0, 1)), par);
    dma_body(8'h02, par, 1'b1, -1, 1'b0, 8'h00, 16'h8000);

    // Reset in the cycle after the 100th OAM write; no done pulse may follow.
    trigger(8'h02, 1'b1, par);
    dma_body(8'h02, par, 1'b0, 100, 1'b0, 8'h00, 16'h9000);
    for (int n = 0; n < 600; n++) begin
      a = rand_addr();
      idle_cycle("after_abort", 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    // Page $FF wrap, with a new trigger accepted in the dma_done cycle.
    pg2 = 8'($urandom);
    trigger(8'hFF, 1'b0, par);
    dma_body(8'hFF, par, 1'b0, -1, 1'b1, pg2, 16'h8000);
    chain_par = cyc[0];
    dma_body(pg2, chain_par, 1'b0, -1, 1'b0, 8'h00, 16'hC000);

    for (int r = 0; r < 3; r++) begin
      pg = 8'($urandom);
      trigger(pg, 1'($urandom_range(0, 1)), par);
      dma_body(pg, par, 1'b0, -1, 1'b0, 8'h00, 16'($urandom_range(16'h8000, 16'hBFFF)));
    end

    for (int n = 0; n < 5; n++) begin
      a = rand_addr();
      idle_cycle("pass_end", 1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
